fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port STALL  input  1  downstream cannot accept a new IF entry this cycle.
REQ-005 SHALL have port BRANCH, UNCOND_BRANCH  input  1 each  control-decoder outputs for the current IF entry.
REQ-006 SHALL have port ZERO  input  1  ALU zero result for the current IF entry.
REQ-007 SHALL have port BRANCH_TARGET  input  64  redirect address.
REQ-008 SHALL have port IMEM_REQ  output  1  instruction-memory request.
REQ-009 SHALL have port IMEM_ADDR  output  64  request address, always equal to PC.
REQ-010 SHALL have port IMEM_VALID  input  1  response valid; completes the request in that cycle.
REQ-011 SHALL have port IMEM_RDATA  input  32  response instruction word.
REQ-012 SHALL have ports IF_VALID (1), IF_INSTR (32), IF_PC (64)  output  fetched-instruction register.
REQ-013 SHALL have port OPCODE  output  11  equal to IF_INSTR[31:21], feeding the control decoder.

Function
REQ-014 SHALL define TAKE = IF_VALID & BRANCH & (UNCOND_BRANCH | ZERO), evaluated combinationally.
REQ-015 SHALL implement states IDLE, REQ, DROP, HOLD; IMEM_REQ is high only in REQ and DROP.
REQ-016 SHALL keep IMEM_ADDR stable while IMEM_REQ is high and IMEM_VALID is low.
REQ-017 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-018 In REQ with IMEM_VALID, no TAKE, and IF free (!IF_VALID | !STALL): load IF with IMEM_RDATA/PC, IF_VALID=1, PC=PC+4 (mod 2^64), and stay in REQ.
REQ-019 In REQ with IMEM_VALID, no TAKE, and IF_VALID & STALL: capture the word and PC in the skid register, then go to HOLD.
REQ-020 HOLD SHALL keep IMEM_REQ low; when STALL falls, move skid to IF, set PC=PC+4, and go to REQ.
REQ-021 On TAKE in any state:
- PC=BRANCH_TARGET; IF_VALID=0; skid discarded.
- If a request is outstanding without IMEM_VALID that cycle, go to DROP; otherwise go to REQ.
REQ-022 TAKE SHALL take priority over STALL and over a coincident IMEM_VALID, whose data is discarded.
REQ-023 DROP SHALL hold the old address until IMEM_VALID, discard that data, then go to REQ with the new PC.
REQ-024 With IF_VALID & !STALL & no new load, IF_VALID SHALL clear next cycle.
REQ-025 Fetch latency SHALL be: IMEM_VALID in cycle N -> IF_VALID in cycle N+1.

Reset
REQ-026 On RST: state=IDLE, PC=RESET_PC, IF_VALID=0, IF_INSTR=0, IF_PC=0, skid empty, IMEM_REQ=0.
REQ-027 RST SHALL override all inputs, and any in-flight response is ignored.
REQ-028 The first request SHALL issue in the second cycle after RST deasserts.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN SHALL add output INSTR_COUNT (32).
- Increments on each IF load; wraps at 2^32; reset to 0.
- Without the macro, the port and counter are absent.

Structure
REQ-030 A shared package SHALL hold the state enum, INSTR_W=32, ADDR_W=64, OPCODE_W=11, and PC_INCR=4.
REQ-031 Sub-module fetch_skid (one-entry skid buffer: word+PC+valid) SHALL be instantiated once.

Verification
REQ-032 Reset with RESET_PC=0x100 and IMEM_VALID returning 0x8B000000 each cycle -> IMEM_ADDR 0x100, 0x104, 0x108; OPCODE=0x458 one cycle after each response.
REQ-033 STALL held for 3 cycles with IF full -> skid captures the next word, IMEM_REQ low; on STALL low, IF shows the skid word and the PC advances by exactly 4.
REQ-034 UNCOND_BRANCH=1, BRANCH=1, target 0x200 -> IF_VALID=0 next cycle; next IMEM_ADDR=0x200.
REQ-035 BRANCH=1, ZERO=0, UNCOND_BRANCH=0 -> no redirect; sequential fetch continues.
REQ-036 TAKE while a request at 0x10C is pending (IMEM_VALID 2 cycles later):
- DROP holds 0x10C and discards its data.
- The next request is 0x200; no 0x10C word reaches IF.
REQ-037 RST mid-DROP -> state IDLE, PC=RESET_PC, response discarded; with FETCH_PERF_CNT_EN, INSTR_COUNT=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared widths, PC increment and fetch FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

   localparam int INSTR_W  = 32;
   localparam int ADDR_W   = 64;
   localparam int OPCODE_W = 11;
   localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t c_idle = 2'd0;
   localparam fetch_state_t c_req  = 2'd1;
   localparam fetch_state_t c_drop = 2'd2;
   localparam fetch_state_t c_hold = 2'd3;

endpackage

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
// Module  : fetch_skid
// Brief   : One-entry skid buffer holding an instruction word and its PC.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid
   import fetch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] wr_instr,
   input  logic [ADDR_W-1:0]  wr_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   logic               r_valid;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (clear) begin
         r_valid <= 1'b0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_instr <= wr_instr;
         r_pc    <= wr_pc;
      end
   end

   assign valid = r_valid;
   assign instr = r_instr;
   assign pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch with IF register, skid buffer and branch redirect.
//           Optional FETCH_PERF_CNT_EN adds the instr_count output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                branch,
   input  logic                uncond_branch,
   input  logic                zero,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_valid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                if_valid,
   output logic [INSTR_W-1:0]  if_instr,
   output logic [ADDR_W-1:0]   if_pc,
   output logic [OPCODE_W-1:0] opcode
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]         instr_count
`endif
);

   fetch_state_t        r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_redirect_pc;
   logic                r_if_valid;
   logic [INSTR_W-1:0]  r_if_instr;
   logic [ADDR_W-1:0]   r_if_pc;

   logic                w_take;
   logic                w_mem_load;
   logic                w_skid_load;
   logic                w_skid_unload;
   logic                w_skid_valid;
   logic [INSTR_W-1:0]  w_skid_instr;
   logic [ADDR_W-1:0]   w_skid_pc;

   assign w_take        = r_if_valid & branch & (uncond_branch | zero);
   assign imem_req      = (r_state == c_req) | (r_state == c_drop);
   assign w_mem_load    = (r_state == c_req) & imem_valid & ~w_take & (~r_if_valid | ~stall);
   assign w_skid_load   = (r_state == c_req) & imem_valid & ~w_take & r_if_valid & stall;
   assign w_skid_unload = (r_state == c_hold) & w_skid_valid & ~stall & ~w_take;

   fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (w_skid_load),
      .clear    (w_take | w_skid_unload),
      .wr_instr (imem_rdata),
      .wr_pc    (r_pc),
      .valid    (w_skid_valid),
      .instr    (w_skid_instr),
      .pc       (w_skid_pc)
   );

   // PC stays on the abandoned address during DROP so imem_addr never moves
   // under an open request; the redirect target waits in r_redirect_pc.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= c_idle;
         r_pc          <= RESET_PC;
         r_redirect_pc <= RESET_PC;
         r_if_valid    <= 1'b0;
         r_if_instr    <= '0;
         r_if_pc       <= '0;
      end else begin
         if (r_if_valid && !stall)
            r_if_valid <= 1'b0;
         if (w_take) begin
            r_if_valid <= 1'b0;
            if (imem_req && !imem_valid) begin
               r_redirect_pc <= branch_target;
               r_state       <= c_drop;
            end else begin
               r_pc    <= branch_target;
               r_state <= c_req;
            end
         end else begin
            case (r_state)
               c_idle: r_state <= c_req;
               c_req: begin
                  if (w_mem_load) begin
                     r_if_valid <= 1'b1;
                     r_if_instr <= imem_rdata;
                     r_if_pc    <= r_pc;
                     r_pc       <= r_pc + PC_INCR;
                  end else if (w_skid_load) begin
                     r_state <= c_hold;
                  end
               end
               c_hold: begin
                  if (w_skid_unload) begin
                     r_if_valid <= 1'b1;
                     r_if_instr <= w_skid_instr;
                     r_if_pc    <= w_skid_pc;
                     r_pc       <= r_pc + PC_INCR;
                     r_state    <= c_req;
                  end
               end
               c_drop: begin
                  if (imem_valid) begin
                     r_pc    <= r_redirect_pc;
                     r_state <= c_req;
                  end
               end
               default: r_state <= c_idle;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_instr_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_instr_count <= '0;
      else if (w_mem_load || w_skid_unload)
         r_instr_count <= r_instr_count + 32'd1;
   end

   assign instr_count = r_instr_count;
`endif

   assign imem_addr = r_pc;
   assign if_valid  = r_if_valid;
   assign if_instr  = r_if_instr;
   assign if_pc     = r_if_pc;
   assign opcode    = r_if_instr[INSTR_W-1 -: OPCODE_W];

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed vector table plus randomized run against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch;
   logic        uncond_branch;
   logic        zero;
   logic [63:0] branch_target;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic [10:0] opcode;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] instr_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   fetch_unit #(.RESET_PC(64'h100)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .zero          (zero),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_valid    (imem_valid),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .opcode        (opcode)
`ifdef FETCH_PERF_CNT_EN
      ,
      .instr_count   (instr_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: fetch pipeline as a PC, an IF slot, a skid queue and a
   // pending-redirect flag.
   typedef struct packed {
      logic [31:0] w;
      logic [63:0] a;
   } ent_t;

   ent_t        m_skid[$];
   bit          m_boot;
   bit          m_drop;
   bit          m_ifv;
   logic [63:0] m_pc;
   logic [63:0] m_tgt;
   logic [31:0] m_instr;
   logic [63:0] m_ifpc;
   logic [31:0] m_cnt;

   function automatic bit m_req();
      return m_boot && (m_skid.size() == 0);
   endfunction

   task automatic m_load(input logic [31:0] w, input logic [63:0] a);
      m_ifv   = 1'b1;
      m_instr = w;
      m_ifpc  = a;
      m_pc    = m_pc + 64'd4;
      m_cnt   = m_cnt + 32'd1;
   endtask

   task automatic model_step(input logic r, s, b, u, z, input logic [63:0] t,
                             input logic v, input logic [31:0] d);
      bit   take;
      bit   req;
      ent_t e;
      take = m_ifv && b && (u || z);
      req  = m_req();
      if (r) begin
         m_skid.delete();
         m_boot = 0; m_drop = 0; m_ifv = 0;
         m_pc = 64'h100; m_tgt = 64'h100; m_instr = '0; m_ifpc = '0; m_cnt = '0;
      end else if (!m_boot) begin
         m_boot = 1;
      end else if (take) begin
         m_skid.delete();
         m_ifv = 0;
         if (req && !v) begin m_drop = 1; m_tgt = t; end
         else begin m_drop = 0; m_pc = t; end
      end else if (m_drop) begin
         if (v) begin m_drop = 0; m_pc = m_tgt; end
      end else if (m_skid.size() != 0) begin
         if (!s) begin e = m_skid.pop_front(); m_load(e.w, e.a); end
      end else if (v && (!m_ifv || !s)) begin
         m_load(d, m_pc);
      end else if (v) begin
         e.w = d; e.a = m_pc;
         m_skid.push_back(e);
      end else if (m_ifv && !s) begin
         m_ifv = 0;
      end
   endtask

   task automatic apply(input logic r, s, b, u, z, input logic [63:0] t,
                        input logic v, input logic [31:0] d);
      rst = r; stall = s; branch = b; uncond_branch = u; zero = z;
      branch_target = t; imem_valid = v; imem_rdata = d;
      model_step(r, s, b, u, z, t, v, d);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst, stall, br, unc, zero;
      logic [63:0] tgt;
      logic        iv;
      logic [31:0] rd;
      logic        e_req;
      logic [63:0] e_addr;
      logic        e_ifv;
      logic [31:0] e_instr;
      logic [63:0] e_ifpc;
      logic [31:0] e_cnt;
   } vec_t;

   function automatic vec_t mk(input logic r, s, b, u, z, input logic [63:0] t,
                               input logic v, input logic [31:0] d,
                               input logic er, input logic [63:0] ea, input logic ev,
                               input logic [31:0] ei, input logic [63:0] ep,
                               input logic [31:0] ec);
      vec_t x;
      x.rst = r; x.stall = s; x.br = b; x.unc = u; x.zero = z; x.tgt = t;
      x.iv = v; x.rd = d; x.e_req = er; x.e_addr = ea; x.e_ifv = ev;
      x.e_instr = ei; x.e_ifpc = ep; x.e_cnt = ec;
      return x;
   endfunction

   localparam logic [31:0] K = 32'h8B00_0000;

   vec_t tbl[29];

   initial begin
      string       tag;
      logic [31:0] exp_instr;
      //             rst st br un z  tgt     iv rdata          req addr    ifv instr          ifpc    cnt
      tbl[0]  = mk(1, 0, 0, 0, 0, 64'h0,   0, 32'h0,          0, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h104, 1, K,              64'h100, 1);
      tbl[3]  = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h108, 1, K,              64'h104, 2);
      tbl[4]  = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h10C, 1, K,              64'h108, 3);
      tbl[5]  = mk(0, 1, 0, 0, 0, 64'h0,   1, 32'hAAAA_0001,  0, 64'h10C, 1, K,              64'h108, 3);
      tbl[6]  = mk(0, 1, 0, 0, 0, 64'h0,   0, 32'h0,          0, 64'h10C, 1, K,              64'h108, 3);
      tbl[7]  = mk(0, 1, 0, 0, 0, 64'h0,   0, 32'h0,          0, 64'h10C, 1, K,              64'h108, 3);
      tbl[8]  = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h110, 1, 32'hAAAA_0001,  64'h10C, 4);
      tbl[9]  = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h110, 0, 32'hAAAA_0001,  64'h10C, 4);
      tbl[10] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'h1234_5678,  1, 64'h114, 1, 32'h1234_5678,  64'h110, 5);
      tbl[11] = mk(0, 0, 1, 0, 0, 64'h200, 1, 32'h1111_1111,  1, 64'h118, 1, 32'h1111_1111,  64'h114, 6);
      tbl[12] = mk(0, 0, 1, 1, 0, 64'h200, 1, 32'h9999_9999,  1, 64'h200, 0, 32'h1111_1111,  64'h114, 6);
      tbl[13] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'h2222_2222,  1, 64'h204, 1, 32'h2222_2222,  64'h200, 7);
      tbl[14] = mk(0, 1, 1, 0, 1, 64'h400, 0, 32'h0,          1, 64'h204, 0, 32'h2222_2222,  64'h200, 7);
      tbl[15] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'hEEEE_EEEE,  1, 64'h400, 0, 32'h2222_2222,  64'h200, 7);
      tbl[16] = mk(1, 0, 0, 0, 0, 64'h0,   0, 32'h0,          0, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[17] = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[18] = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h104, 1, K,              64'h100, 1);
      tbl[19] = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h108, 1, K,              64'h104, 2);
      tbl[20] = mk(0, 0, 0, 0, 0, 64'h0,   1, K,              1, 64'h10C, 1, K,              64'h108, 3);
      tbl[21] = mk(0, 0, 1, 1, 0, 64'h200, 0, 32'h0,          1, 64'h10C, 0, K,              64'h108, 3);
      tbl[22] = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h10C, 0, K,              64'h108, 3);
      tbl[23] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'hDEAD_BEEF,  1, 64'h200, 0, K,              64'h108, 3);
      tbl[24] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'h5555_5555,  1, 64'h204, 1, 32'h5555_5555,  64'h200, 4);
      tbl[25] = mk(0, 0, 1, 1, 0, 64'h300, 0, 32'h0,          1, 64'h204, 0, 32'h5555_5555,  64'h200, 4);
      tbl[26] = mk(1, 0, 0, 0, 0, 64'h0,   1, 32'h6666_6666,  0, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[27] = mk(0, 0, 0, 0, 0, 64'h0,   0, 32'h0,          1, 64'h100, 0, 32'h0,          64'h0,   0);
      tbl[28] = mk(0, 0, 0, 0, 0, 64'h0,   1, 32'h7777_7777,  1, 64'h104, 1, 32'h7777_7777,  64'h100, 1);

      for (int i = 0; i < 29; i++) begin
         apply(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].unc, tbl[i].zero,
               tbl[i].tgt, tbl[i].iv, tbl[i].rd);
         tag = $sformatf("row%0d", i);
         exp_instr = tbl[i].e_instr;
         chk({tag, "_imem_req"},  imem_req,  tbl[i].e_req);
         chk({tag, "_imem_addr"}, imem_addr, tbl[i].e_addr);
         chk({tag, "_if_valid"},  if_valid,  tbl[i].e_ifv);
         chk({tag, "_if_instr"},  if_instr,  tbl[i].e_instr);
         chk({tag, "_if_pc"},     if_pc,     tbl[i].e_ifpc);
         chk({tag, "_opcode"},    opcode,    exp_instr[31:21]);
`ifdef FETCH_PERF_CNT_EN
         chk({tag, "_instr_count"}, instr_count, tbl[i].e_cnt);
`endif
      end

      // Randomized run against the model; memory only answers open requests.
      apply(1, 0, 0, 0, 0, 64'h0, 0, 32'h0);
      for (int c = 0; c < 3000; c++) begin
         logic        r, s, b, u, z, v;
         logic [63:0] t;
         r = ($urandom % 300) == 0;
         s = ($urandom % 3) == 0;
         b = ($urandom % 5) == 0;
         u = $urandom % 2;
         z = $urandom % 2;
         t = {$urandom, $urandom} & ~64'h3;
         v = m_req() && (($urandom % 2) == 0);
         apply(r, s, b, u, z, t, v, $urandom);
         chk("rnd_imem_req",  imem_req,  m_req());
         chk("rnd_imem_addr", imem_addr, m_pc);
         chk("rnd_if_valid",  if_valid,  m_ifv);
         chk("rnd_if_instr",  if_instr,  m_instr);
         chk("rnd_if_pc",     if_pc,     m_ifpc);
         chk("rnd_opcode",    opcode,    m_instr[31:21]);
`ifdef FETCH_PERF_CNT_EN
         chk("rnd_instr_count", instr_count, m_cnt);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
